// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes and the decoded control bundle.
package alu_pkg;

    localparam int unsigned CTRL_W = 3;

    typedef logic [CTRL_W-1:0] alu_code_t;

    localparam alu_code_t ALU_ADD = 3'b000;
    localparam alu_code_t ALU_SUB = 3'b001;
    localparam alu_code_t ALU_AND = 3'b010;
    localparam alu_code_t ALU_OR  = 3'b011;
    localparam alu_code_t ALU_XOR = 3'b100;
    localparam alu_code_t ALU_SLL = 3'b101;
    localparam alu_code_t ALU_SRL = 3'b110;
    localparam alu_code_t ALU_SLT = 3'b111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // src_b_sel: 1 selects the immediate, 0 selects rs2_data
    typedef struct packed {
        alu_code_t ctrl;
        logic      src_b_sel;
        logic      illegal;
    } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I -> ALU control decode. Define ALU_SLT_EN to decode SLT/SLTI to code 111.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_dec_t    dec_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^instr[24:7] ^ ^instr[11:7];

    always_comb begin
        dec_c = '{ctrl: ALU_ADD, src_b_sel: 1'b0, illegal: 1'b0};
        unique case (opcode)
            OP_R: begin
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)     dec_c.ctrl = ALU_ADD;
                        else if (funct7 == F7_ALT) dec_c.ctrl = ALU_SUB;
                        else                       dec_c.illegal = 1'b1;
                    end
                    3'b111: dec_c.ctrl = ALU_AND;
                    3'b110: dec_c.ctrl = ALU_OR;
                    3'b100: dec_c.ctrl = ALU_XOR;
                    3'b001: if (funct7 == F7_ZERO) dec_c.ctrl = ALU_SLL; else dec_c.illegal = 1'b1;
                    3'b101: if (funct7 == F7_ZERO) dec_c.ctrl = ALU_SRL; else dec_c.illegal = 1'b1;
`ifdef ALU_SLT_EN
                    3'b010: if (funct7 == F7_ZERO) dec_c.ctrl = ALU_SLT; else dec_c.illegal = 1'b1;
`endif
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OP_I: begin
                dec_c.src_b_sel = 1'b1;
                unique case (funct3)
                    3'b000: dec_c.ctrl = ALU_ADD;
                    3'b111: dec_c.ctrl = ALU_AND;
                    3'b110: dec_c.ctrl = ALU_OR;
                    3'b100: dec_c.ctrl = ALU_XOR;
                    3'b001: if (funct7 == F7_ZERO) dec_c.ctrl = ALU_SLL; else dec_c.illegal = 1'b1;
                    // SRAI (funct7 0100000) has no ALU code and falls out as illegal
                    3'b101: if (funct7 == F7_ZERO) dec_c.ctrl = ALU_SRL; else dec_c.illegal = 1'b1;
`ifdef ALU_SLT_EN
                    3'b010: dec_c.ctrl = ALU_SLT;
`endif
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: dec_c.src_b_sel = 1'b1;
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) dec_c.ctrl = ALU_SUB;
                else                                      dec_c.illegal = 1'b1;
            end
            default: dec_c.illegal = 1'b1;
        endcase
        // illegal beats always present the ADD code to the ALU
        if (dec_c.illegal) dec_c.ctrl = ALU_ADD;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: decode, operand select, one-entry valid/ready hold with flush.
// Define ALU_SLT_EN to enable signed set-less-than decode (code 111).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CONTROL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CONTROL_WIDTH-1:0] alu_ctrl,
    output logic [DATA_WIDTH-1:0]    src_a,
    output logic [DATA_WIDTH-1:0]    src_b,
    output logic                     illegal
);

    alu_dec_t dec_c;
    logic     accept_c;

    alu_ctrl_decode u_decode (
        .instr (instr),
        .dec_c (dec_c)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Flush beats accept; data registers only move on a real accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_ctrl  <= '0;
            src_a     <= '0;
            src_b     <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            alu_ctrl  <= CONTROL_WIDTH'(dec_c.ctrl);
            src_a     <= rs1_data;
            src_b     <= dec_c.src_b_sel ? imm : rs2_data;
            illegal   <= dec_c.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (both ALU_SLT_EN builds).
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .illegal   (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b, input logic ill);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(c));
        chk({tag, ".src_a"},     src_a,          a);
        chk({tag, ".src_b"},     src_b,          b);
        chk({tag, ".illegal"},   32'(illegal),   32'(ill));
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        in_valid = 1'b1;
        instr    = i;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_out("reset", 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // add x3,x1,x2
        drive(32'h002081B3, 32'd7, 32'd5, 32'h99);
        tick();
        in_valid = 1'b0;
        chk_out("add", 1'b1, 3'b000, 32'd7, 32'd5, 1'b0);

        // sub then addi back-to-back
        drive(32'h402081B3, 32'd9, 32'd4, 32'h55);
        tick();
        chk_out("sub", 1'b1, 3'b001, 32'd9, 32'd4, 1'b0);
        drive(32'h00500093, 32'd0, 32'h77, 32'd5);
        tick();
        in_valid = 1'b0;
        chk_out("addi", 1'b1, 3'b000, 32'd0, 32'd5, 1'b0);
        tick();
        chk_out("drain_hold", 1'b0, 3'b000, 32'd0, 32'd5, 1'b0);

        // backpressure: xor held 3 cycles while or waits
        drive(32'h0020C1B3, 32'hF0, 32'hFF, 32'h0);
        tick();
        chk_out("xor", 1'b1, 3'b100, 32'hF0, 32'hFF, 1'b0);
        out_ready = 1'b0;
        drive(32'h0020E1B3, 32'd1, 32'd2, 32'h0);
        #1;
        chk("stall.in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("stall_hold", 1'b1, 3'b100, 32'hF0, 32'hFF, 1'b0);
            chk("stall_hold.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("or_after_stall", 1'b1, 3'b011, 32'd1, 32'd2, 1'b0);
        tick();
        chk("or_consumed.out_valid", 32'(out_valid), 32'd0);

        // flush while holding stalled and with a new beat offered
        drive(32'h0020F1B3, 32'd3, 32'd6, 32'h0);
        tick();
        chk_out("and", 1'b1, 3'b010, 32'd3, 32'd6, 1'b0);
        out_ready = 1'b0;
        drive(32'h402081B3, 32'd11, 32'd12, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_out("flush_stalled", 1'b0, 3'b010, 32'd3, 32'd6, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("flush_none_emitted", 32'(out_valid), 32'd0);

        // flush beats a simultaneous accept
        drive(32'h402081B3, 32'd13, 32'd14, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_out("flush_accept", 1'b0, 3'b010, 32'd3, 32'd6, 1'b0);

        // slt x3,x1,x2
        drive(32'h0020A1B3, 32'd21, 32'd22, 32'h0);
        tick();
`ifdef ALU_SLT_EN
        chk_out("slt", 1'b1, 3'b111, 32'd21, 32'd22, 1'b0);
`else
        chk_out("slt", 1'b1, 3'b000, 32'd21, 32'd22, 1'b1);
`endif
        // srai x1,x1,3: illegal, operands still registered
        drive(32'h4030D093, 32'd31, 32'd32, 32'h403);
        tick();
        chk_out("srai", 1'b1, 3'b000, 32'd31, 32'h403, 1'b1);
        // sltu x3,x1,x2: illegal in both builds
        drive(32'h0020B1B3, 32'd41, 32'd42, 32'h0);
        tick();
        chk_out("sltu", 1'b1, 3'b000, 32'd41, 32'd42, 1'b1);
        // bne x1,x2,0
        drive(32'h00209063, 32'd51, 32'd52, 32'h0);
        tick();
        chk_out("bne", 1'b1, 3'b001, 32'd51, 32'd52, 1'b0);
        // blt: unsupported branch
        drive(32'h0020C063, 32'd61, 32'd62, 32'h0);
        tick();
        chk_out("blt", 1'b1, 3'b000, 32'd61, 32'd62, 1'b1);
        // lw x3,4(x1)
        drive(32'h0040A183, 32'd71, 32'd72, 32'd4);
        tick();
        chk_out("lw", 1'b1, 3'b000, 32'd71, 32'd4, 1'b0);
        // sw x2,8(x1)
        drive(32'h0020A423, 32'd81, 32'd82, 32'd8);
        tick();
        chk_out("sw", 1'b1, 3'b000, 32'd81, 32'd8, 1'b0);
        // slli x1,x1,2 / srli x1,x1,1
        drive(32'h00209093, 32'd91, 32'd92, 32'd2);
        tick();
        chk_out("slli", 1'b1, 3'b101, 32'd91, 32'd2, 1'b0);
        drive(32'h0010D093, 32'd93, 32'd94, 32'd1);
        tick();
        chk_out("srli", 1'b1, 3'b110, 32'd93, 32'd1, 1'b0);
        // lui: unknown opcode
        drive(32'h000010B7, 32'd101, 32'd102, 32'h1000);
        tick();
        in_valid = 1'b0;
        chk_out("lui", 1'b1, 3'b000, 32'd101, 32'd102, 1'b1);
        tick();

        // reset asserted mid-stall
        drive(32'h0020E1B3, 32'h123, 32'h456, 32'h0);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_out("pre_rst_stall", 1'b1, 3'b011, 32'h123, 32'h456, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rst_mid_stall", 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
        chk("rst_mid_stall.in_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
